// File: rtl/axis_pkg.sv
// Shared AXI-Stream arbitration types and the round-robin pick function.
package axis_pkg;

  typedef enum logic {IDLE, LOCK} arb_state_t;

  localparam int RR_MAX   = 32;
  localparam int RR_IDX_W = 5;

  // Requests above ptr take precedence; otherwise wrap to the lowest requester.
  function automatic logic [RR_IDX_W-1:0] rr_next(input logic [RR_MAX-1:0] req,
                                                 input logic [RR_IDX_W-1:0] ptr);
    logic [RR_MAX-1:0] hi_mask;
    logic [RR_MAX-1:0] masked;
    logic [RR_MAX-1:0] pool;
    for (int i = 0; i < RR_MAX; i++) hi_mask[i] = (RR_IDX_W'(i) > ptr);
    masked  = req & hi_mask;
    pool    = (masked != '0) ? masked : req;
    rr_next = '0;
    for (int i = RR_MAX - 1; i >= 0; i--) if (pool[i]) rr_next = RR_IDX_W'(i);
  endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// Combinational mask-based round-robin picker: first requester after ptr, cyclic.
module axis_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_vld
);
  import axis_pkg::*;

  logic [RR_MAX-1:0]   req_ext;
  logic [RR_IDX_W-1:0] ptr_ext;

  always_comb begin
    req_ext                 = '0;
    req_ext[NUM_PORTS-1:0]  = req;
    ptr_ext                 = '0;
    ptr_ext[IDX_W-1:0]      = ptr;
  end

  assign gnt_idx = IDX_W'(rr_next(req_ext, ptr_ext));
  assign gnt_vld = |req;

endmodule

// File: rtl/axis_rr_arb_mux.sv
// Frame-locked round-robin N:1 AXI-Stream mux with a registered output stage,
// feeding the shared downstream FIFO.
module axis_rr_arb_mux #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
  parameter int LAST_ENABLE = 1,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_WIDTH  = 1,
  localparam int IDX_W      = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_axis_tuser,
  input  logic [NUM_PORTS*ID_WIDTH-1:0]    s_axis_tid,
  input  logic [NUM_PORTS*DEST_WIDTH-1:0]  s_axis_tdest,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  output logic [DEST_WIDTH-1:0]            m_axis_tdest,
  output logic [IDX_W-1:0]                 grant_idx,
  output logic                             busy
);
  import axis_pkg::*;

  arb_state_t            state, state_nxt;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_vld;
  logic                  ready_g, accept, release_frame;
  logic                  sel_valid, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic [USER_WIDTH-1:0] sel_user;
  logic [ID_WIDTH-1:0]   sel_id;
  logic [DEST_WIDTH-1:0] sel_dest;

  axis_rr_arbiter #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_arb (
    .req     (s_axis_tvalid),
    .ptr     (rr_ptr),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    sel_id    = '0;
    sel_dest  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        sel_id    = s_axis_tid[i*ID_WIDTH +: ID_WIDTH];
        sel_dest  = s_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH];
      end
    end
  end

  // The output register can take a beat whenever it is empty or draining.
  assign ready_g       = m_axis_tready | ~m_axis_tvalid;
  assign accept        = (state == LOCK) & sel_valid & ready_g;
  assign release_frame = accept & ((LAST_ENABLE != 0) ? sel_last : 1'b1);
  assign busy          = (state == LOCK);

  always_comb begin
    s_axis_tready = '0;
    if (state == LOCK) s_axis_tready[grant_idx] = ready_g;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (arb_vld) state_nxt = LOCK;
      LOCK: if (release_frame) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_idx <= '0;
      rr_ptr    <= IDX_W'(NUM_PORTS - 1);
    end else begin
      if (state == IDLE && arb_vld) grant_idx <= arb_idx;
      if (release_frame)            rr_ptr    <= grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tid    <= '0;
      m_axis_tdest  <= '0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sel_data;
      m_axis_tlast  <= (LAST_ENABLE != 0) ? sel_last : 1'b1;
      m_axis_tkeep  <= (KEEP_ENABLE != 0) ? sel_keep : '1;
      m_axis_tuser  <= sel_user;
      m_axis_tid    <= sel_id;
      m_axis_tdest  <= sel_dest;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_rr_arb_mux.sv
// Directed bench for axis_rr_arb_mux: one frame-locked instance and one with
// LAST_ENABLE=0 sharing the same stimulus.
module tb_axis_rr_arb_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid, s_tlast, s_tkeep, s_tuser;
  logic [31:0] s_tid, s_tdest;
  logic        m_tready;

  logic [3:0]  s_tready_a, s_tready_b;
  logic [7:0]  m_tdata_a, m_tdata_b, m_tid_a, m_tid_b, m_tdest_a, m_tdest_b;
  logic        m_tvalid_a, m_tvalid_b, m_tlast_a, m_tlast_b;
  logic [0:0]  m_tkeep_a, m_tkeep_b, m_tuser_a, m_tuser_b;
  logic [1:0]  grant_a, grant_b;
  logic        busy_a, busy_b;

  logic [8:0]  src_q [4][$];
  logic [25:0] log_a [$];
  logic [25:0] log_b [$];
  bit          use_nl = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  axis_rr_arb_mux #(.NUM_PORTS(4), .DATA_WIDTH(8), .LAST_ENABLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_a),
    .s_axis_tlast(s_tlast), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tid(s_tid), .s_axis_tdest(s_tdest),
    .m_axis_tdata(m_tdata_a), .m_axis_tvalid(m_tvalid_a), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast_a), .m_axis_tkeep(m_tkeep_a), .m_axis_tuser(m_tuser_a),
    .m_axis_tid(m_tid_a), .m_axis_tdest(m_tdest_a),
    .grant_idx(grant_a), .busy(busy_a)
  );

  axis_rr_arb_mux #(.NUM_PORTS(4), .DATA_WIDTH(8), .LAST_ENABLE(0)) dut_nl (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_b),
    .s_axis_tlast(s_tlast), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tid(s_tid), .s_axis_tdest(s_tdest),
    .m_axis_tdata(m_tdata_b), .m_axis_tvalid(m_tvalid_b), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast_b), .m_axis_tkeep(m_tkeep_b), .m_axis_tuser(m_tuser_b),
    .m_axis_tid(m_tid_b), .m_axis_tdest(m_tdest_b),
    .grant_idx(grant_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected output beat: {tuser, tdest, tid, tlast, tdata}; sideband is fixed per port.
  function automatic logic [25:0] ent(input int p, input logic l, input logic [7:0] d);
    return {1'(p), 8'(8'hD0 + p), 8'(8'hC0 + p), l, d};
  endfunction

  task automatic drive();
    logic [8:0] b;
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() != 0) begin
        b = src_q[i][0];
        s_tvalid[i]       = 1'b1;
        s_tdata[i*8 +: 8] = b[7:0];
        s_tlast[i]        = b[8];
      end else begin
        s_tvalid[i]       = 1'b0;
        s_tdata[i*8 +: 8] = 8'h00;
        s_tlast[i]        = 1'b0;
      end
    end
  endtask

  // Sample handshakes at negedge, advance the sources just after the next posedge.
  task automatic step();
    logic [3:0] hs;
    @(negedge clk);
    hs = s_tvalid & (use_nl ? s_tready_b : s_tready_a);
    if (m_tvalid_a && m_tready) log_a.push_back({m_tuser_a, m_tdest_a, m_tid_a, m_tlast_a, m_tdata_a});
    if (m_tvalid_b && m_tready) log_b.push_back({m_tuser_b, m_tdest_b, m_tid_b, m_tlast_b, m_tdata_b});
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (hs[i]) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic load_frame(input int p, input logic [7:0] base, input int n, input logic with_last);
    for (int k = 0; k < n; k++)
      src_q[p].push_back({(with_last && k == n - 1), 8'(base + k)});
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) src_q[i].delete();
    log_a.delete();
    log_b.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush();
    drive();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int k = 0;
    while (((use_nl ? log_b.size() : log_a.size()) < n) && k < budget) begin
      step();
      k++;
    end
    chk(tag, use_nl ? log_b.size() : log_a.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; s_tkeep = '0;
    for (int i = 0; i < 4; i++) begin
      s_tid[i*8 +: 8]   = 8'(8'hC0 + i);
      s_tdest[i*8 +: 8] = 8'(8'hD0 + i);
      s_tuser[i]        = 1'(i);
    end
    m_tready = 1'b1;

    // Reset held with every port requesting
    for (int i = 0; i < 4; i++) load_frame(i, 8'(8'h10 + i), 1, 1'b1);
    drive();
    step();
    step();
    chk("rst_tready", s_tready_a, 4'h0);
    chk("rst_mvalid", m_tvalid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_grant", grant_a, 0);
    chk("rst_mdata", m_tdata_a, 0);
    rst_n = 1'b1;
    step();
    chk("first_grant", grant_a, 0);
    chk("first_busy", busy_a, 1);
    run_until("t1_drain", 4, 60);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1_beat%0d", i), (log_a.size() > i) ? log_a[i] : 26'h0, ent(i, 1'b1, 8'(8'h10 + i)));

    // Single port, four beats, cycle-exact
    flush();
    load_frame(2, 8'hA0, 4, 1'b1);
    drive();
    step();
    chk("t2_grant", grant_a, 2);
    chk("t2_busy_a", busy_a, 1);
    chk("t2_mvalid_a", m_tvalid_a, 0);
    chk("t2_tready", s_tready_a, 4'h4);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t2_data%0d", k), m_tdata_a, 8'hA0 + k);
      chk($sformatf("t2_valid%0d", k), m_tvalid_a, 1);
      chk($sformatf("t2_last%0d", k), m_tlast_a, (k == 3) ? 1 : 0);
      chk($sformatf("t2_busy%0d", k), busy_a, (k == 3) ? 0 : 1);
    end
    step();
    chk("t2_mvalid_end", m_tvalid_a, 0);

    // Round robin across all ports, port 0 holds two frames
    do_reset();
    load_frame(0, 8'h00, 2, 1'b1);
    load_frame(0, 8'h02, 2, 1'b1);
    for (int i = 1; i < 4; i++) load_frame(i, 8'(i * 16), 2, 1'b1);
    drive();
    run_until("t3_drain", 10, 100);
    begin
      logic [25:0] exp3 [10];
      exp3[0] = ent(0, 0, 8'h00); exp3[1] = ent(0, 1, 8'h01);
      exp3[2] = ent(1, 0, 8'h10); exp3[3] = ent(1, 1, 8'h11);
      exp3[4] = ent(2, 0, 8'h20); exp3[5] = ent(2, 1, 8'h21);
      exp3[6] = ent(3, 0, 8'h30); exp3[7] = ent(3, 1, 8'h31);
      exp3[8] = ent(0, 0, 8'h02); exp3[9] = ent(0, 1, 8'h03);
      for (int i = 0; i < 10; i++)
        chk($sformatf("t3_beat%0d", i), (log_a.size() > i) ? log_a[i] : 26'h0, exp3[i]);
    end
    chk("t3_tkeep_forced", m_tkeep_a, 1);

    // Backpressure mid-frame
    do_reset();
    load_frame(1, 8'h40, 4, 1'b1);
    drive();
    step();
    chk("t4_grant", grant_a, 1);
    step();
    chk("t4_d0", m_tdata_a, 8'h40);
    step();
    chk("t4_d1", m_tdata_a, 8'h41);
    m_tready = 1'b0;
    step();
    chk("t4_stall1_data", m_tdata_a, 8'h41);
    chk("t4_stall1_valid", m_tvalid_a, 1);
    chk("t4_stall1_tready", s_tready_a, 4'h0);
    step();
    chk("t4_stall2_data", m_tdata_a, 8'h41);
    m_tready = 1'b1;
    run_until("t4_drain", 4, 40);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t4_beat%0d", i), (log_a.size() > i) ? log_a[i] : 26'h0,
          ent(1, (i == 3), 8'(8'h40 + i)));
    step();
    step();
    chk("t4_no_dup", log_a.size(), 4);

    // Reset in the middle of a five-beat frame
    do_reset();
    load_frame(2, 8'h60, 5, 1'b1);
    drive();
    step();
    step();
    step();
    chk("t6_mid_data", m_tdata_a, 8'h61);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_mvalid", m_tvalid_a, 0);
    chk("t6_rst_busy", busy_a, 0);
    chk("t6_rst_tready", s_tready_a, 4'h0);
    flush();
    load_frame(2, 8'h60, 5, 1'b1);
    load_frame(0, 8'h70, 1, 1'b1);
    drive();
    step();
    rst_n = 1'b1;
    step();
    chk("t6_regrant", grant_a, 0);
    run_until("t6_drain", 6, 60);
    chk("t6_beat0", (log_a.size() > 0) ? log_a[0] : 26'h0, ent(0, 1, 8'h70));
    for (int i = 0; i < 5; i++)
      chk($sformatf("t6_beat%0d", i + 1), (log_a.size() > i + 1) ? log_a[i + 1] : 26'h0,
          ent(2, (i == 4), 8'(8'h60 + i)));

    // LAST_ENABLE=0 instance: every beat is its own frame
    use_nl = 1'b1;
    do_reset();
    load_frame(1, 8'h51, 3, 1'b0);
    load_frame(3, 8'h91, 3, 1'b0);
    drive();
    run_until("t5_drain", 6, 80);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t5_beat%0d", i), (log_b.size() > i) ? log_b[i] : 26'h0,
          ent((i % 2 == 0) ? 1 : 3, 1'b1, 8'(((i % 2 == 0) ? 8'h51 : 8'h91) + i / 2)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
